// File: rtl/eca_pkg.sv
// Shared types and constants for the elementary cellular automaton row engine.
package eca_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int RULE_W = 8;
   localparam int NBHD_W = 3;

   localparam logic [RULE_W-1:0] RULE_30  = 8'd30;
   localparam logic [RULE_W-1:0] RULE_90  = 8'd90;
   localparam logic [RULE_W-1:0] RULE_110 = 8'd110;
   localparam logic [RULE_W-1:0] RULE_204 = 8'd204;
endpackage

// File: rtl/eca_row_engine_if.sv
// Load / run handshake bundle between the pattern source and the row engine.
interface eca_row_engine_if #(
   parameter int WIDTH = 16,
   parameter int GEN_W = 8
);
   logic [7:0]       rule;
   logic             load_valid;
   logic             load_bit;
   logic             load_ready;
   logic             start;
   logic [GEN_W-1:0] gen_count;
   logic             busy;
   logic             done;
   logic             loaded;
   logic [WIDTH-1:0] row;

   modport master (
      output rule, load_valid, load_bit, start, gen_count,
      input  load_ready, busy, done, loaded, row
   );

   modport slave (
      input  rule, load_valid, load_bit, start, gen_count,
      output load_ready, busy, done, loaded, row
   );
endinterface

// File: rtl/eca_cell_rule.sv
// One cell's next state: selects rule bit indexed by {left, centre, right}.
module eca_cell_rule
   import eca_pkg::*;
(
   input  logic [RULE_W-1:0] rule,
   input  logic [NBHD_W-1:0] nbhd,
   output logic              nxt
);
   logic [3:0] l1;
   logic [1:0] l2;

   // Tree resolves nbhd LSB first, so l1[k] = rule[{k, nbhd[0]}].
   for (genvar k = 0; k < 4; k++) begin : g_l1
      eca_mux2 u_mux (.a(rule[2*k]), .b(rule[2*k+1]), .sel(nbhd[0]), .y(l1[k]));
   end

   for (genvar k = 0; k < 2; k++) begin : g_l2
      eca_mux2 u_mux (.a(l1[2*k]), .b(l1[2*k+1]), .sel(nbhd[1]), .y(l2[k]));
   end

   eca_mux2 u_mux_top (.a(l2[0]), .b(l2[1]), .sel(nbhd[2]), .y(nxt));
endmodule

// File: rtl/eca_mux2.sv
// Generic 2:1 single-bit multiplexer.
module eca_mux2 (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic y
);
   assign y = sel ? b : a;
endmodule

// File: rtl/eca_row_engine.sv
// Holds one ECA row: serial MSB-first load, then evolves it for gen_count
// generations under the sampled Wolfram rule with periodic boundaries.
module eca_row_engine
   import eca_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GEN_W = 8
) (
   input logic              clk,
   input logic              rst,
   eca_row_engine_if.slave  bus
);
   localparam int              PTR_W   = $clog2(WIDTH);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(WIDTH - 1);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   row_q, row_nxt;
   logic [PTR_W-1:0]   ptr;
   logic               loaded_q;
   logic [RULE_W-1:0]  rule_q;
   logic [GEN_W-1:0]   remaining;
   logic               start_acc, load_acc;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      eca_cell_rule u_cell (
         .rule (rule_q),
         .nbhd ({row_q[(i+1)%WIDTH], row_q[i], row_q[(i+WIDTH-1)%WIDTH]}),
         .nxt  (row_nxt[i])
      );
   end

   always_comb begin
      state_nxt      = state;
      start_acc      = 1'b0;
      load_acc       = 1'b0;
      bus.load_ready = 1'b0;
      unique case (state)
         IDLE: begin
            bus.load_ready = ~bus.start;
            start_acc      = bus.start & loaded_q;
            load_acc       = bus.load_valid & ~bus.start;
            if (start_acc) state_nxt = (bus.gen_count != '0) ? RUN : DONE;
         end
         RUN:     if (remaining == GEN_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         row_q     <= '0;
         ptr       <= PTR_MAX;
         loaded_q  <= 1'b0;
         rule_q    <= '0;
         remaining <= '0;
      end else begin
         state <= state_nxt;
         if (start_acc) begin
            rule_q    <= bus.rule;
            remaining <= bus.gen_count;
            ptr       <= PTR_MAX;
         end else if (load_acc) begin
            row_q[ptr] <= bus.load_bit;
            ptr        <= (ptr == '0) ? PTR_MAX : ptr - PTR_W'(1);
            if (ptr == PTR_MAX)  loaded_q <= 1'b0;
            else if (ptr == '0)  loaded_q <= 1'b1;
         end
         if (state == RUN) begin
            row_q     <= row_nxt;
            remaining <= remaining - GEN_W'(1);
         end
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE);
   assign bus.loaded = loaded_q;
   assign bus.row    = row_q;
endmodule
